keypad_scanner: RTL and testbench

- Drives the column strobes of a 4x4 matrix keypad and samples the row returns.
- Debounces presses and releases, then delivers one 4-bit key code per physical press over a valid/ready handshake.
- Sits between the keypad pins and the input-consuming logic.
- Uses a single system clock with an internal scan-rate enable tick; no derived clock leaves this block.

---
 rtl/keypad_scanner_pkg.sv | 48 ++++
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/keypad_scanner_scan_tick_gen.sv | 34 +++
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Column strobe encoding and lowest-row selection live here.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } scan_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } row_sel_t;

  function automatic logic [COLS-1:0] col_onehot_n(
    input logic [1:0] idx
  );
    logic [COLS-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Lowest active (low) row wins; no ghost rejection.
  function automatic row_sel_t lowest_row(
    input logic [ROWS-1:0] r_n
  );
    row_sel_t s;
    s.hit = ~&r_n;
    s.idx = 2'd0;
    if (!r_n[0]) begin
      s.idx = 2'd0;
    end else if (!r_n[1]) begin
      s.idx = 2'd1;
    end else if (!r_n[2]) begin
      s.idx = 2'd2;
    end else if (!r_n[3]) begin
      s.idx = 2'd3;
    end
    return s;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Valid/ready key delivery channel between scanner and consumer.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic      key_valid;
  logic      key_ready;
  key_code_t key_code;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );

endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Prescaler: one-clk enable every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int WIDTH    = 32,
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [WIDTH-1:0] LAST =
    WIDTH'(SCAN_DIV - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and
// one key code per physical press on a valid/ready channel.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROWS-1:0]     row_n,
  output logic [COLS-1:0]     col_n,
  keypad_scanner_if.master    key_if,
  output logic                key_pressed,
  output logic                overrun
);

  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CNT);

  logic            tick;
  logic [ROWS-1:0] sync1_q;
  logic [ROWS-1:0] sync2_q;
  row_sel_t        sel;

  scan_state_t state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cnt_inc;
  logic        emit;

  logic      valid_q, valid_d;
  key_code_t code_q, code_d;
  logic      ovr_q, ovr_d;

  scan_tick_gen #(
    .WIDTH    (WIDTH),
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  assign sel     = lowest_row(sync2_q);
  assign cnt_inc = cnt_q + 4'd1;

  // Column only moves on ticks; it stays frozen
  // while a candidate is debounced or held.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (sel.hit) begin
            row_d = sel.idx;
            if (DB_MAX == 4'd1) begin
              emit    = 1'b1;
              state_d = HOLD;
              cnt_d   = 4'd0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (sel.hit && (sel.idx == row_q)) begin
            if (cnt_inc >= DB_MAX) begin
              emit    = 1'b1;
              state_d = HOLD;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            cnt_d   = 4'd0;
          end
        end
        HOLD: begin
          if (sync2_q[row_q]) begin
            if (cnt_inc >= DB_MAX) begin
              state_d = SCAN;
              col_d   = col_q + 2'd1;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled key wins over a new one; a same-cycle
  // transfer lets the new key replace it.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = 1'b0;
    if (emit) begin
      if (valid_q && !key_if.key_ready) begin
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = {row_d, col_q};
      end
    end else if (valid_q && key_if.key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign col_n            = col_onehot_n(col_q);
  assign key_pressed      = (state_q == HOLD);
  assign overrun          = ovr_q;
  assign key_if.key_valid = valid_q;
  assign key_if.key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed sequences, a vector table
// and a randomized press stream against a key-event scoreboard.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_pressed;
  logic        overrun;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .WIDTH        (32),
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_if      (kif),
    .key_pressed (key_pressed),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Matrix model: bit r*4+c shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end
  end

  typedef struct packed {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [3:0] strobe(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return kif.key_valid;
      1: return key_pressed;
      default: return overrun;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl,
                          input int lim, input string nm);
    int k;
    k = 0;
    while (sig(which) !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (sig(which) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s timeout act=%b exp=%b",
               nm, sig(which), lvl);
    end
  endtask

  int         pulses;
  logic [3:0] exp_q[$];
  int         xfers;
  int         ovr_seen;
  int         presses;
  bit         rnd_done;

  initial begin
    tbl[0] = '{keys: 16'h0020, code: 4'h5};
    tbl[1] = '{keys: 16'h8000, code: 4'hF};
    tbl[2] = '{keys: 16'h1010, code: 4'h4};
    tbl[3] = '{keys: 16'h0808, code: 4'h3};
    tbl[4] = '{keys: 16'h0040, code: 4'h6};
    tbl[5] = '{keys: 16'h0001, code: 4'h0};

    keys = '0;
    kif.key_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_col", 32'(col_n), 32'h0000000E);
    chk("rst_valid", 32'(kif.key_valid), 0);
    chk("rst_code", 32'(kif.key_code), 0);
    chk("rst_pressed", 32'(key_pressed), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan: column index advances once per 4 clks.
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      chk("idle_col", 32'(col_n), 32'(strobe((n / 4) % 4)));
      chk("idle_valid", 32'(kif.key_valid), 0);
    end

    // Row 2 / col 1 press, single delivery, release.
    keys = 16'h0200;
    wait_for(0, 1'b1, 80, "k9_valid");
    chk("k9_code", 32'(kif.key_code), 32'h9);
    chk("k9_pressed", 32'(key_pressed), 1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (kif.key_valid) pulses++;
    end
    chk("k9_repeat", 32'(pulses), 0);
    keys = '0;
    wait_for(1, 1'b0, 60, "k9_release");
    chk("k9_next_col", 32'(col_n), 32'h0000000B);

    // One-tick bounce on row 0 / col 3.
    wait_for(0, 1'b0, 4, "bn_idle");
    while (col_n == 4'b0111) @(negedge clk);
    wait_for(1, 1'b0, 4, "bn_nohold");
    begin
      int k;
      k = 0;
      while (col_n != 4'b0111 && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    chk("bn_col3", 32'(col_n), 32'h00000007);
    keys = 16'h0008;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (kif.key_valid) pulses++;
    end
    keys = '0;
    repeat (4) begin
      @(negedge clk);
      if (kif.key_valid) pulses++;
    end
    chk("bn_col0", 32'(col_n), 32'h0000000E);
    repeat (20) begin
      @(negedge clk);
      if (kif.key_valid || key_pressed) pulses++;
    end
    chk("bn_nokey", 32'(pulses), 0);

    for (int i = 0; i < 6; i++) begin
      keys = tbl[i].keys;
      wait_for(0, 1'b1, 80, "tbl_valid");
      chk("tbl_code", 32'(kif.key_code), 32'(tbl[i].code));
      pulses = 0;
      repeat (30) begin
        @(negedge clk);
        if (kif.key_valid) pulses++;
      end
      chk("tbl_repeat", 32'(pulses), 0);
      keys = '0;
      wait_for(1, 1'b0, 60, "tbl_release");
      repeat (8) @(negedge clk);
    end

    // Stalled consumer: second key is dropped with overrun.
    kif.key_ready = 1'b0;
    keys = 16'h0001;
    wait_for(0, 1'b1, 80, "ov_valid");
    chk("ov_code0", 32'(kif.key_code), 0);
    keys = '0;
    wait_for(1, 1'b0, 60, "ov_rel0");
    keys = 16'h4000;
    wait_for(2, 1'b1, 100, "ov_pulse");
    chk("ov_keep_code", 32'(kif.key_code), 0);
    chk("ov_keep_valid", 32'(kif.key_valid), 1);
    @(negedge clk);
    chk("ov_one_clk", 32'(overrun), 0);
    keys = '0;
    wait_for(1, 1'b0, 60, "ov_rel1");
    kif.key_ready = 1'b1;
    @(negedge clk);
    chk("ov_clear", 32'(kif.key_valid), 0);

    // Reset in the middle of a debounce.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    keys = 16'h0100;
    repeat (8) @(negedge clk);
    chk("md_nokey", 32'(kif.key_valid | key_pressed), 0);
    reset = 1'b1;
    #1;
    chk("md_col", 32'(col_n), 32'h0000000E);
    chk("md_outs", 32'({kif.key_valid, key_pressed, overrun}), 0);
    chk("md_code", 32'(kif.key_code), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 11) chk("md_early", 32'(kif.key_valid), 0);
      if (n == 12) begin
        chk("md_emit", 32'(kif.key_valid), 1);
        chk("md_code8", 32'(kif.key_code), 32'h8);
      end
    end
    keys = '0;
    wait_for(1, 1'b0, 60, "md_release");
    repeat (8) @(negedge clk);

    // Random single-key presses vs. an event scoreboard.
    xfers = 0;
    ovr_seen = 0;
    presses = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [3:0]  c;
          logic [15:0] one;
          c = 4'($urandom_range(15));
          one = 16'h0001;
          exp_q.push_back(c);
          keys = one << c;
          repeat ($urandom_range(80, 60)) @(negedge clk);
          keys = '0;
          repeat ($urandom_range(60, 45)) @(negedge clk);
          presses++;
        end
        repeat (20) @(negedge clk);
        rnd_done = 1'b1;
      end
      begin
        int wcnt;
        wcnt = 0;
        while (!rnd_done) begin
          @(negedge clk);
          if (kif.key_valid) wcnt++;
          else wcnt = 0;
          kif.key_ready = (wcnt > 6) ? 1'b1 :
                          1'($urandom_range(1));
          if (overrun) ovr_seen++;
          if (kif.key_valid && kif.key_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rnd_extra act=%0h exp=none",
                       kif.key_code);
            end else begin
              chk("rnd_code", 32'(kif.key_code),
                  32'(exp_q.pop_front()));
            end
          end
        end
      end
    join
    chk("rnd_xfers", 32'(xfers), 32'(presses));
    chk("rnd_pending", 32'(exp_q.size()), 0);
    chk("rnd_overrun", 32'(ovr_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
